fifo_flow: RTL and testbench
============================

// Module: fifo_flow
// PURPOSE
//  Parametrised successor to the NoC router input FIFO. It adds:
//   - an occupancy count output
//   - programmable almost-full/almost-empty thresholds
//   - protected writes and reads (rejected when full/empty)
//   - sticky overflow/underflow error flags
//   - a selectable first-word-fall-through (FWFT) read mode
//  Sits between the link receiver and the router arbiter. Storage is internal.
// PARAMETERS
//  WIDTH     32        data word width
//  DEPTH     32        entries; must equal 2**ADDWIDTH
//  ADDWIDTH  5         pointer width
//  AF_LEVEL  DEPTH-2   almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  1         almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//  FWFT      0         0: registered read data, 1-cycle latency; 1: head word visible on dataOut
// PORTS
//  clk           in   1           clock, all state on posedge
//  reset         in   1           synchronous, active-high
//  write         in   1           write request
//  read          in   1           read request
//  dataIn        in   WIDTH       write data
//  clear_err     in   1           clears overflow/underflow
//  dataOut       out  WIDTH       read data
//  full          out  1           count == DEPTH
//  almost_full   out  1           count >= AF_LEVEL
//  empty         out  1           count == 0
//  almost_empty  out  1           count <= AE_LEVEL
//  count         out  ADDWIDTH+1  current occupancy, 0..DEPTH
//  overflow      out  1           sticky: write rejected
//  underflow     out  1           sticky: read rejected
// BEHAVIOUR
//  - Reset (sync, dominates everything):
//    - head=tail=count=0; empty=1, almost_empty=1, full=0, almost_full=0 (AF_LEVEL>0)
//    - overflow=underflow=0; dataOut=0
//    - Memory contents are not reset.
//    - Reset mid-stream discards all stored words; the next cycle behaves as post-reset.
//  - Accepted transfers:
//    - rd_ok = read & ~empty
//    - wr_ok = write & (~full | rd_ok)
//    - A full FIFO with read&write accepts both; count is unchanged.
//  - Empty FIFO with read&write: write accepted, read rejected, underflow set.
//  - On wr_ok: mem[head] <= dataIn; head <= head+1 (wraps DEPTH-1 -> 0).
//  - On rd_ok: tail <= tail+1 (wraps).
//  - count <= count + wr_ok - rd_ok. Never exceeds DEPTH or goes below 0.
//  - All flags derive from the registered count (no combinational path from write/read).
//  - Flags change in the cycle after the accepted transfer.
//  - FWFT=0:
//    - On rd_ok, dataOut <= mem[tail]; valid the cycle after read.
//    - Otherwise dataOut holds its value.
//  - FWFT=1:
//    - dataOut = mem[tail] whenever ~empty; rd_ok pops it.
//    - A word written into an empty FIFO appears on dataOut the cycle after the write.
//    - dataOut is don't-care while empty.
//  - Error flags:
//    - overflow <= 1 on write & ~wr_ok.
//    - underflow <= 1 on read & empty.
//    - clear_err clears both; a new error in the same cycle wins (flag stays 1).
// TESTING
//  - Reset, then idle 3 cycles -> empty=1, almost_empty=1, count=0, full=0, dataOut=0.
//  - FWFT=0, DEPTH=32: write 0..31 on consecutive cycles:
//    - -> almost_full rises when count=30, full=1 when count=32
//    - A 33rd write -> overflow=1, count stays 32.
//    - Read 32 -> dataOut 0..31 in order, one cycle after each read.
//  - Full FIFO, read&write same cycle with dataIn=0xAA -> count stays 32, no overflow; 0xAA read out last.
//  - Empty FIFO, read&write with dataIn=0x55 -> underflow=1, count=1; FWFT=1 dataOut=0x55 next cycle.
//  - Pointer wrap: 100 interleaved write/read pairs with an incrementing pattern -> output sequence matches input, count never >1.
//  - Set overflow, assert clear_err -> overflow=0 next cycle; mid-fill reset (count=10) -> count=0, empty=1 next cycle.

Source files
------------

// File: rtl/fifo_flow.sv
// -----------------------------------------------------------------------------
// fifo_flow
//
// Purpose
//   Synchronous FIFO between the link receiver and the router arbiter.
//   Provides an occupancy count, programmable almost-full/almost-empty
//   thresholds, and protected writes and reads: a write to a full FIFO or a
//   read from an empty one is rejected. Rejected requests set sticky error
//   flags. Read data is either registered (one-cycle latency) or
//   first-word-fall-through, selected at build time.
//
// Parameters
//   WIDTH     data word width
//   DEPTH     number of entries, must equal 2**ADDWIDTH
//   ADDWIDTH  pointer width
//   AF_LEVEL  almost_full when count >= AF_LEVEL   (1..DEPTH)
//   AE_LEVEL  almost_empty when count <= AE_LEVEL  (0..DEPTH-1)
//   FWFT      0: dataOut registered on an accepted read
//             1: head word shown on dataOut while not empty
//
// Ports
//   clk           clock; all state changes on the rising edge
//   reset         synchronous, active-high; overrides every other input
//   write, read   transfer requests
//   dataIn        write data
//   clear_err     clears overflow/underflow
//   dataOut       read data
//   full, almost_full, empty, almost_empty
//                 occupancy flags, decoded from the registered count
//   count         occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
// -----------------------------------------------------------------------------
module fifo_flow #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDWIDTH = 5,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1,
  parameter bit FWFT     = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write,
  input  logic                read,
  input  logic [WIDTH-1:0]    dataIn,
  input  logic                clear_err,
  output logic [WIDTH-1:0]    dataOut,
  output logic                full,
  output logic                almost_full,
  output logic                empty,
  output logic                almost_empty,
  output logic [ADDWIDTH:0]   count,
  output logic                overflow,
  output logic                underflow
);

  // Reject parameter sets that the pointer arithmetic cannot support.
  if (DEPTH != 2**ADDWIDTH) begin : g_bad_depth
    $error("fifo_flow: DEPTH must equal 2**ADDWIDTH");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_flow: AF_LEVEL out of range 1..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_flow: AE_LEVEL out of range 0..DEPTH-1");
  end

  localparam logic [ADDWIDTH:0] DEPTH_CNT = (ADDWIDTH + 1)'(DEPTH);
  localparam logic [ADDWIDTH:0] AF_CNT    = (ADDWIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDWIDTH:0] AE_CNT    = (ADDWIDTH + 1)'(AE_LEVEL);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDWIDTH-1:0] head;
  logic [ADDWIDTH-1:0] tail;
  logic                rd_ok;
  logic                wr_ok;

  // A read frees a slot in the same cycle, so a full FIFO may accept a
  // write alongside a read. An empty FIFO never accepts a read, even if a
  // write arrives in the same cycle.
  assign rd_ok = read & ~empty;
  assign wr_ok = write & (~full | rd_ok);

  // Flags decode the registered count only, so no combinational path runs
  // from write/read to them.
  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (wr_ok) head <= head + 1'b1;
      if (rd_ok) tail <= tail + 1'b1;
      count <= count + (ADDWIDTH + 1)'(wr_ok) - (ADDWIDTH + 1)'(rd_ok);
    end
  end

  // NOTE: the storage array is deliberately left out of reset. Reset makes
  // the contents unreachable through the pointers, and skipping the array
  // keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (wr_ok && !reset) mem[head] <= dataIn;
  end

  // Sticky error flags. A new error in the same cycle as clear_err keeps
  // the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write && !wr_ok) overflow <= 1'b1;
      else if (clear_err)  overflow <= 1'b0;

      if (read && empty)   underflow <= 1'b1;
      else if (clear_err)  underflow <= 1'b0;
    end
  end

  if (FWFT) begin : g_fwft
    // The head word is visible while data is stored. Driving zero while
    // empty gives a defined value after reset.
    assign dataOut = empty ? '0 : mem[tail];
  end else begin : g_registered
    logic [WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (reset)      dout_q <= '0;
      else if (rd_ok) dout_q <= mem[tail];
    end

    assign dataOut = dout_q;
  end

endmodule

// File: tb/tb_fifo_flow.sv
// -----------------------------------------------------------------------------
// tb_fifo_flow
//
// Drives two fifo_flow instances from the same inputs: one with registered
// read data and one with first-word-fall-through. A reference model tracks
// occupancy and the sticky error flags. A scoreboard queue holds every
// accepted write word and pops one word for each accepted read.
// -----------------------------------------------------------------------------
module tb_fifo_flow;

  localparam int W = 32;
  localparam int D = 32;
  localparam int A = 5;

  logic         clk;
  logic         reset;
  logic         write;
  logic         read;
  logic [W-1:0] dataIn;
  logic         clear_err;

  logic [W-1:0] d0_dout, d1_dout;
  logic         d0_full, d0_afull, d0_empty, d0_aempty, d0_ovf, d0_udf;
  logic         d1_full, d1_afull, d1_empty, d1_aempty, d1_ovf, d1_udf;
  logic [A:0]   d0_count, d1_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [W-1:0] sb[$];
  int           m_count;
  logic         m_ovf;
  logic         m_udf;

  fifo_flow #(.WIDTH(W), .DEPTH(D), .ADDWIDTH(A), .FWFT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .write(write), .read(read), .dataIn(dataIn),
    .clear_err(clear_err), .dataOut(d0_dout), .full(d0_full),
    .almost_full(d0_afull), .empty(d0_empty), .almost_empty(d0_aempty),
    .count(d0_count), .overflow(d0_ovf), .underflow(d0_udf)
  );

  fifo_flow #(.WIDTH(W), .DEPTH(D), .ADDWIDTH(A), .FWFT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .write(write), .read(read), .dataIn(dataIn),
    .clear_err(clear_err), .dataOut(d1_dout), .full(d1_full),
    .almost_full(d1_afull), .empty(d1_empty), .almost_empty(d1_aempty),
    .count(d1_count), .overflow(d1_ovf), .underflow(d1_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle of stimulus. Inputs are applied 1 ns after an edge and
  // outputs are sampled 1 ns after the next edge. The scoreboard checks read
  // data: the FWFT head word before the edge, and the registered word after it.
  task automatic step(input logic w, input logic r, input logic [W-1:0] d,
                      input logic ce, input logic rst);
    logic         rd_ok, wr_ok, udf_evt;
    logic [W-1:0] exp;
    write = w; read = r; dataIn = d; clear_err = ce; reset = rst;
    rd_ok   = r && (m_count != 0);
    wr_ok   = w && ((m_count != D) || rd_ok);
    udf_evt = r && (m_count == 0);
    if (!rst && rd_ok) begin
      checks++;
      if (d1_dout !== sb[0]) begin
        failures++;
        $display("FAIL fwft_head: got %0h expected %0h", d1_dout, sb[0]);
      end
    end
    @(posedge clk); #1;
    if (rst) begin
      sb.delete();
      m_count = 0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      if (rd_ok) begin
        exp = sb.pop_front();
        checks++;
        if (d0_dout !== exp) begin
          failures++;
          $display("FAIL reg_dout: got %0h expected %0h", d0_dout, exp);
        end
      end
      if (wr_ok) sb.push_back(d);
      m_count = m_count + int'(wr_ok) - int'(rd_ok);
      if (w && !wr_ok) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
      if (udf_evt)     m_udf = 1'b1; else if (ce) m_udf = 1'b0;
    end
    write = 1'b0; read = 1'b0; clear_err = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if ({d0_empty, d0_aempty, d0_full, d0_afull} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 1100",
               {d0_empty, d0_aempty, d0_full, d0_afull});
    end
    checks++;
    if (d0_count !== '0 || d1_count !== '0) begin
      failures++;
      $display("FAIL reset_count: got %0d/%0d expected 0", d0_count, d1_count);
    end
    checks++;
    if (d0_dout !== '0) begin
      failures++;
      $display("FAIL reset_dout: got %0h expected 0", d0_dout);
    end
    checks++;
    if ({d0_ovf, d0_udf} !== 2'b00) begin
      failures++;
      $display("FAIL reset_err: got %b expected 00", {d0_ovf, d0_udf});
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) begin
      step(1'b1, 1'b0, W'(i), 1'b0, 1'b0);
      checks++;
      if (d0_count !== (A + 1)'(i + 1)) begin
        failures++;
        $display("FAIL fill_count: got %0d expected %0d", d0_count, i + 1);
      end
      checks++;
      if (d0_afull !== (i + 1 >= D - 2) || d0_full !== (i + 1 == D)) begin
        failures++;
        $display("FAIL fill_flags: got af=%b f=%b at count %0d",
                 d0_afull, d0_full, i + 1);
      end
    end
    // 33rd write is rejected.
    step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checks++;
    if (d0_ovf !== 1'b1 || d1_ovf !== 1'b1 || d0_count !== (A + 1)'(D)) begin
      failures++;
      $display("FAIL overflow_set: got ovf=%b/%b count=%0d expected 1/1 32",
               d0_ovf, d1_ovf, d0_count);
    end
  endtask

  task automatic test_clear_err();
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (d0_ovf !== m_ovf) begin
      failures++;
      $display("FAIL clear_ovf: got %b expected %b", d0_ovf, m_ovf);
    end
    // A rejected write in the same cycle as clear_err keeps the flag set.
    step(1'b1, 1'b0, 32'h1234, 1'b1, 1'b0);
    checks++;
    if (d0_ovf !== 1'b1) begin
      failures++;
      $display("FAIL clear_vs_new: got %b expected 1", d0_ovf);
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (d0_ovf !== 1'b0 || d0_count !== (A + 1)'(m_count)) begin
      failures++;
      $display("FAIL clear_again: got ovf=%b count=%0d expected 0 %0d",
               d0_ovf, d0_count, m_count);
    end
  endtask

  task automatic test_full_rw();
    step(1'b1, 1'b1, 32'hAA, 1'b0, 1'b0);
    checks++;
    if (d0_count !== (A + 1)'(D) || d0_ovf !== 1'b0 || d0_full !== 1'b1) begin
      failures++;
      $display("FAIL full_rw: got count=%0d ovf=%b full=%b expected 32 0 1",
               d0_count, d0_ovf, d0_full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, '0, 1'b0, 1'b0);
      checks++;
      if (d0_count !== (A + 1)'(m_count) || d0_aempty !== (m_count <= 1) ||
          d0_empty !== (m_count == 0)) begin
        failures++;
        $display("FAIL drain_flags: got count=%0d ae=%b e=%b expected %0d",
                 d0_count, d0_aempty, d0_empty, m_count);
      end
    end
    checks++;
    if (d0_dout !== 32'hAA) begin
      failures++;
      $display("FAIL drain_last: got %0h expected aa", d0_dout);
    end
  endtask

  task automatic test_empty_rw();
    step(1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
    checks++;
    if (d0_udf !== 1'b1 || d1_udf !== 1'b1 || d0_count !== (A + 1)'(1)) begin
      failures++;
      $display("FAIL empty_rw: got udf=%b/%b count=%0d expected 1/1 1",
               d0_udf, d1_udf, d0_count);
    end
    checks++;
    if (d1_dout !== 32'h55) begin
      failures++;
      $display("FAIL empty_rw_fwft: got %0h expected 55", d1_dout);
    end
    step(1'b0, 1'b1, '0, 1'b1, 1'b0);
    checks++;
    if (d0_udf !== 1'b0 || d0_empty !== 1'b1) begin
      failures++;
      $display("FAIL udf_clear: got udf=%b empty=%b expected 0 1",
               d0_udf, d0_empty);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, W'(32'h1000 + i), 1'b0, 1'b0);
      checks++;
      if (d0_count !== (A + 1)'(1)) begin
        failures++;
        $display("FAIL wrap_wr: got %0d expected 1 at pair %0d", d0_count, i);
      end
      step(1'b0, 1'b1, '0, 1'b0, 1'b0);
      checks++;
      if (d0_count !== '0) begin
        failures++;
        $display("FAIL wrap_rd: got %0d expected 0 at pair %0d", d0_count, i);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, W'($urandom), 1'b0, 1'b0);
      checks++;
      if (d0_count !== (A + 1)'(5) || d1_count !== (A + 1)'(5)) begin
        failures++;
        $display("FAIL b2b_count: got %0d/%0d expected 5", d0_count, d1_count);
      end
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, W'(32'h200 + i), 1'b0, 1'b0);
    checks++;
    if (d0_count !== (A + 1)'(10)) begin
      failures++;
      $display("FAIL pre_reset: got %0d expected 10", d0_count);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (d0_count !== '0 || d0_empty !== 1'b1 || d0_dout !== '0) begin
      failures++;
      $display("FAIL mid_reset: got count=%0d empty=%b dout=%0h expected 0 1 0",
               d0_count, d0_empty, d0_dout);
    end
    // The first word after reset is the first one read back.
    step(1'b1, 1'b0, 32'h77, 1'b0, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0, 1'b0);
    checks++;
    if (d0_dout !== 32'h77 || d0_empty !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: got %0h empty=%b expected 77 1",
               d0_dout, d0_empty);
    end
  endtask

  initial begin
    reset = 1'b0; write = 1'b0; read = 1'b0; dataIn = '0; clear_err = 1'b0;
    m_count = 0; m_ovf = 1'b0; m_udf = 1'b0;
    test_reset();
    test_fill();
    test_clear_err();
    test_full_rw();
    test_drain();
    test_empty_rw();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
